// File: rtl/j4_uart.sv
// rtl/j4_uart.sv - memory-mapped 8N1 UART target for the j4 core I/O bus
// Receiver, RX FIFO and RX status flags are built only when J4_UART_RX_EN is defined.
module j4_uart #(
    parameter logic [15:0] BASE      = 16'h4000,
    parameter logic [15:0] DIV_RESET = 16'd433,
    parameter int          TX_AW     = 2,
    parameter int          RX_AW     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_we,
    input  logic        io_re,
    input  logic [15:0] io_ptr,
    input  logic [15:0] io_out,
    output logic [15:0] io_in,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam logic [TX_AW:0] TX_INC = 1;

    logic w_hit0, w_hit1, w_hit2;
    assign w_hit0 = (io_ptr == BASE);
    assign w_hit1 = (io_ptr == BASE + 16'd1);
    assign w_hit2 = (io_ptr == BASE + 16'd2);

    logic [15:0] r_div;
    always_ff @(posedge clk) begin
        if (rst)                  r_div <= DIV_RESET;
        else if (io_we && w_hit2) r_div <= io_out;
    end

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    tx_state_t      r_tx_state;
    logic [9:0]     r_tx_sh;
    logic [3:0]     r_tx_bitn;
    logic [15:0]    r_tx_cnt;
    logic           r_tx_out;
    logic [7:0]     r_tx_mem [2**TX_AW];
    logic [TX_AW:0] r_tx_wp, r_tx_rp, w_tx_cnt;
    logic           w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_last, w_tx_busy;
    logic [7:0]     w_tx_head;

    // Pointers carry one extra bit so a full FIFO is distinguishable from empty.
    assign w_tx_cnt   = r_tx_wp - r_tx_rp;
    assign w_tx_empty = (w_tx_cnt == '0);
    assign w_tx_full  = w_tx_cnt[TX_AW];
    assign w_tx_head  = r_tx_mem[r_tx_rp[TX_AW-1:0]];
    assign w_tx_last  = (r_tx_state == TX_SHIFT) && (r_tx_cnt == 16'd0) && (r_tx_bitn == 4'd9);
    assign w_tx_pop   = ((r_tx_state == TX_IDLE) || w_tx_last) && !w_tx_empty;
    assign w_tx_push  = io_we && w_hit0 && (!w_tx_full || w_tx_pop);
    assign w_tx_busy  = !w_tx_empty || (r_tx_state == TX_SHIFT);
    assign uart_tx    = r_tx_out;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[TX_AW-1:0]] <= io_out[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + TX_INC;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_INC;
        end
    end

    // A pop at the end of the stop bit reloads on the same edge: no idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_sh    <= '1;
            r_tx_bitn  <= 4'd0;
            r_tx_cnt   <= 16'd0;
            r_tx_out   <= 1'b1;
        end else if (w_tx_pop) begin
            r_tx_state <= TX_SHIFT;
            r_tx_sh    <= {1'b1, w_tx_head, 1'b0};
            r_tx_bitn  <= 4'd0;
            r_tx_cnt   <= r_div;
            r_tx_out   <= 1'b0;
        end else if (r_tx_state == TX_SHIFT) begin
            if (r_tx_cnt != 16'd0) begin
                r_tx_cnt <= r_tx_cnt - 16'd1;
            end else if (r_tx_bitn == 4'd9) begin
                r_tx_state <= TX_IDLE;
                r_tx_out   <= 1'b1;
            end else begin
                r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
                r_tx_out  <= r_tx_sh[1];
                r_tx_bitn <= r_tx_bitn + 4'd1;
                r_tx_cnt  <= r_div;
            end
        end
    end

    logic       w_rx_valid, w_ovr, w_ferr;
    logic [7:0] w_rx_data;

`ifdef J4_UART_RX_EN
    localparam logic [RX_AW:0] RX_INC = 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t      r_rx_state;
    logic           r_rx_s1, r_rx_s2, r_rx_prev, r_rx_brk, r_rx_ovr, r_rx_ferr;
    logic [15:0]    r_rx_cnt;
    logic [2:0]     r_rx_bitn;
    logic [7:0]     r_rx_sh;
    logic [7:0]     r_rx_mem [2**RX_AW];
    logic [RX_AW:0] r_rx_wp, r_rx_rp, w_rx_cnt;
    logic           w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_done, w_rx_bad, w_rx_smp;
    logic [16:0]    w_div_p1;
    logic [15:0]    w_half;

    assign w_div_p1   = {1'b0, r_div} + 17'd1;
    assign w_half     = w_div_p1[16:1] - 16'd1;
    assign w_rx_cnt   = r_rx_wp - r_rx_rp;
    assign w_rx_empty = (w_rx_cnt == '0);
    assign w_rx_full  = w_rx_cnt[RX_AW];
    assign w_rx_smp   = (r_rx_state == RX_STOP) && !r_rx_brk && (r_rx_cnt == 16'd0);
    assign w_rx_done  = w_rx_smp && r_rx_s2;
    assign w_rx_bad   = w_rx_smp && !r_rx_s2;
    assign w_rx_pop   = io_re && w_hit0 && !w_rx_empty;
    assign w_rx_push  = w_rx_done && (!w_rx_full || w_rx_pop);
    assign w_rx_valid = !w_rx_empty;
    assign w_rx_data  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[RX_AW-1:0]];
    assign w_ovr      = r_rx_ovr;
    assign w_ferr     = r_rx_ferr;

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp[RX_AW-1:0]] <= r_rx_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_rx_ovr  <= 1'b0;
            r_rx_ferr <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + RX_INC;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_INC;
            if (io_we && w_hit1 && io_out[2]) r_rx_ovr  <= 1'b0;
            if (io_we && w_hit1 && io_out[3]) r_rx_ferr <= 1'b0;
            if (w_rx_done && w_rx_full && !w_rx_pop) r_rx_ovr <= 1'b1;
            if (w_rx_bad) r_rx_ferr <= 1'b1;
        end
    end

    // After a bad stop bit, r_rx_brk holds STOP until the line returns high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_bitn  <= 3'd0;
            r_rx_sh    <= 8'h00;
            r_rx_brk   <= 1'b0;
        end else begin
            r_rx_s1   <= uart_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_s2 && r_rx_prev) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= w_half;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt != 16'd0) r_rx_cnt <= r_rx_cnt - 16'd1;
                    else if (r_rx_s2)      r_rx_state <= RX_IDLE;
                    else begin
                        r_rx_state <= RX_DATA;
                        r_rx_cnt   <= r_div;
                        r_rx_bitn  <= 3'd0;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt != 16'd0) r_rx_cnt <= r_rx_cnt - 16'd1;
                    else begin
                        r_rx_sh   <= {r_rx_s2, r_rx_sh[7:1]};
                        r_rx_bitn <= r_rx_bitn + 3'd1;
                        r_rx_cnt  <= r_div;
                        if (r_rx_bitn == 3'd7) r_rx_state <= RX_STOP;
                    end
                end
                default: begin
                    if (r_rx_brk) begin
                        if (r_rx_s2) begin
                            r_rx_brk   <= 1'b0;
                            r_rx_state <= RX_IDLE;
                        end
                    end else if (r_rx_cnt != 16'd0) r_rx_cnt <= r_rx_cnt - 16'd1;
                    else if (r_rx_s2)              r_rx_state <= RX_IDLE;
                    else                           r_rx_brk <= 1'b1;
                end
            endcase
        end
    end
`else
    logic w_unused;
    assign w_unused   = ^{io_re, uart_rx};
    assign w_rx_valid = 1'b0;
    assign w_ovr      = 1'b0;
    assign w_ferr     = 1'b0;
    assign w_rx_data  = 8'h00;
`endif

    always_comb begin
        io_in = 16'h0000;
        if (w_hit0)      io_in = {8'h00, w_rx_data};
        else if (w_hit1) io_in = {11'd0, w_tx_busy, w_ferr, w_ovr, w_tx_full, w_rx_valid};
        else if (w_hit2) io_in = r_div;
    end
endmodule

// File: tb/tb_j4_uart.sv
// tb/tb_j4_uart.sv - directed self-checking bench for j4_uart
module tb_j4_uart;
    localparam logic [15:0] BASE = 16'h4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_we = 1'b0;
    logic        io_re = 1'b0;
    logic [15:0] io_ptr = 16'h0000;
    logic [15:0] io_out = 16'h0000;
    logic [15:0] io_in;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    j4_uart dut (
        .clk(clk), .rst(rst), .io_we(io_we), .io_re(io_re), .io_ptr(io_ptr),
        .io_out(io_out), .io_in(io_in), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        io_ptr = addr; io_out = data; io_we = 1'b1;
        @(negedge clk);
        io_we = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic pop, output logic [15:0] data);
        @(negedge clk);
        io_ptr = addr; io_re = pop;
        #1 data = io_in;
        @(negedge clk);
        io_re = 1'b0;
    endtask

    // Drives one 8N1 frame at 8 cycles per bit (DIV = 7), starting on a negedge.
    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            uart_rx = fr[b];
            repeat (8) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic test_reset;
        logic [15:0] v;
        int bad;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus_read(BASE + 16'd1, 1'b0, v);
        n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL reset_status: got %h want 0000", v); end
        bus_read(BASE + 16'd2, 1'b0, v);
        n_cmp++; if (v !== 16'h01B1) begin n_bad++; $display("FAIL reset_div: got %h want 01b1", v); end
        bus_read(BASE, 1'b0, v);
        n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h want 0000", v); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (uart_tx !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL reset_tx_idle: %0d low cycles, want 0", bad); end
    endtask

    task automatic test_tx_frame;
        logic [15:0] v;
        logic [9:0]  fr;
        int bad, busy_bad, first;
        bus_write(BASE + 16'd2, 16'd3);
        bus_read(BASE + 16'd2, 1'b0, v);
        n_cmp++; if (v !== 16'h0003) begin n_bad++; $display("FAIL div_rw: got %h want 0003", v); end
        bus_write(BASE, 16'h00A5);
        io_ptr = BASE + 16'd1; #1;
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL tx_before_load: got %b want 1", uart_tx); end
        n_cmp++; if (io_in[4] !== 1'b1) begin n_bad++; $display("FAIL tx_busy_queued: got %b want 1", io_in[4]); end
        fr = {1'b1, 8'hA5, 1'b0};
        bad = 0; busy_bad = 0; first = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (uart_tx !== fr[i/4]) begin bad++; if (first < 0) first = i; end
            if (io_in[4] !== 1'b1) busy_bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL tx_a5_wave: %0d wrong cycles (first %0d), want 0", bad, first); end
        n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL tx_busy_frame: %0d idle cycles, want 0", busy_bad); end
        @(negedge clk); #1;
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL tx_after_stop: got %b want 1", uart_tx); end
        n_cmp++; if (io_in !== 16'h0000) begin n_bad++; $display("FAIL tx_busy_clear: status %h want 0000", io_in); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [6];
        logic [9:0] fr;
        logic       e;
        int bad, first, j;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
        bad = 0; first = -1;
        @(negedge clk);
        io_ptr = BASE; io_out = {8'h00, bytes[0]}; io_we = 1'b1;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (i < 4) io_out = {8'h00, bytes[i+1]};
            else if (i == 4) begin
                io_we = 1'b0; io_ptr = BASE + 16'd1; #1;
                n_cmp++; if (io_in[1] !== 1'b1) begin n_bad++; $display("FAIL b2b_full: got %b want 1", io_in[1]); end
                io_ptr = BASE; io_out = {8'h00, bytes[5]}; io_we = 1'b1;
            end else if (i == 5) begin
                io_we = 1'b0; io_ptr = BASE + 16'd1; #1;
                n_cmp++; if (io_in[1] !== 1'b1) begin n_bad++; $display("FAIL b2b_full_after_drop: got %b want 1", io_in[1]); end
            end
            #1;
            j = i - 1;
            if (i == 0 || j >= 200) e = 1'b1;
            else begin
                fr = {1'b1, bytes[j/40], 1'b0};
                e  = fr[(j%40)/4];
            end
            if (uart_tx !== e) begin bad++; if (first < 0) first = i; end
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL b2b_wave: %0d wrong cycles (first %0d), want 0", bad, first); end
        n_cmp++; if (io_in !== 16'h0000) begin n_bad++; $display("FAIL b2b_idle: status %h want 0000", io_in); end
    endtask

    task automatic test_ignore;
        logic [15:0] v;
        int bad;
        bus_write(BASE + 16'd3, 16'hFFFF);
        bus_write(16'h3FFF, 16'h0042);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (uart_tx !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL ignore_tx: %0d low cycles, want 0", bad); end
        bus_read(BASE + 16'd1, 1'b0, v);
        n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL ignore_status: got %h want 0000", v); end
        bus_read(BASE + 16'd2, 1'b0, v);
        n_cmp++; if (v !== 16'h0003) begin n_bad++; $display("FAIL ignore_div: got %h want 0003", v); end
        bus_read(BASE + 16'd3, 1'b1, v);
        n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL ignore_read_base3: got %h want 0000", v); end
        bus_read(16'h3FFF, 1'b1, v);
        n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL ignore_read_3fff: got %h want 0000", v); end
    endtask

`ifdef J4_UART_RX_EN
    task automatic test_rx_single;
        logic [15:0] v;
        bus_write(BASE + 16'd2, 16'd7);
        @(negedge clk);
        send_rx(8'h3C, 1'b1);
        bus_read(BASE + 16'd1, 1'b0, v);
        n_cmp++; if (v !== 16'h0001) begin n_bad++; $display("FAIL rx_valid: status %h want 0001", v); end
        bus_read(BASE, 1'b1, v);
        n_cmp++; if (v !== 16'h003C) begin n_bad++; $display("FAIL rx_data: got %h want 003c", v); end
        bus_read(BASE, 1'b1, v);
        n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL rx_empty_read: got %h want 0000", v); end
        bus_read(BASE + 16'd1, 1'b0, v);
        n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL rx_valid_clear: status %h want 0000", v); end
    endtask

    task automatic test_rx_errors;
        logic [15:0] v;
        logic [7:0]  d [5];
        d[0] = 8'hA1; d[1] = 8'hB2; d[2] = 8'hC3; d[3] = 8'hD4; d[4] = 8'hE5;
        @(negedge clk);
        for (int k = 0; k < 5; k++) send_rx(d[k], 1'b1);
        repeat (4) @(negedge clk);
        bus_read(BASE + 16'd1, 1'b0, v);
        n_cmp++; if (v !== 16'h0005) begin n_bad++; $display("FAIL rx_overrun: status %h want 0005", v); end
        for (int k = 0; k < 4; k++) begin
            bus_read(BASE, 1'b1, v);
            n_cmp++; if (v !== {8'h00, d[k]}) begin n_bad++; $display("FAIL rx_fifo_order[%0d]: got %h want %h", k, v, {8'h00, d[k]}); end
        end
        bus_read(BASE + 16'd1, 1'b0, v);
        n_cmp++; if (v !== 16'h0004) begin n_bad++; $display("FAIL rx_drained: status %h want 0004", v); end
        @(negedge clk);
        send_rx(8'h77, 1'b0);
        repeat (6) @(negedge clk);
        bus_read(BASE + 16'd1, 1'b0, v);
        n_cmp++; if (v !== 16'h000C) begin n_bad++; $display("FAIL rx_frame_err: status %h want 000c", v); end
        bus_write(BASE + 16'd1, 16'h000C);
        bus_read(BASE + 16'd1, 1'b0, v);
        n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL rx_flag_clear: status %h want 0000", v); end
    endtask
`else
    task automatic test_no_rx;
        logic [15:0] v;
        bus_write(BASE + 16'd2, 16'd7);
        @(negedge clk);
        send_rx(8'h3C, 1'b1);
        send_rx(8'h77, 1'b0);
        repeat (6) @(negedge clk);
        bus_read(BASE + 16'd1, 1'b0, v);
        n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL norx_status: got %h want 0000", v); end
        bus_read(BASE, 1'b1, v);
        n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL norx_data: got %h want 0000", v); end
        bus_read(BASE + 16'd2, 1'b0, v);
        n_cmp++; if (v !== 16'h0007) begin n_bad++; $display("FAIL norx_div: got %h want 0007", v); end
    endtask
`endif

    task automatic test_mid_reset;
        logic [15:0] v;
        int bad;
        bus_write(BASE + 16'd2, 16'd3);
        bus_write(BASE, 16'h005A);
        bus_write(BASE, 16'h005B);
        #1;
        n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL midrst_in_frame: got %b want 0", uart_tx); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL midrst_tx_high: got %b want 1", uart_tx); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (uart_tx !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL midrst_fifo_flushed: %0d low cycles, want 0", bad); end
        bus_read(BASE + 16'd1, 1'b0, v);
        n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL midrst_status: got %h want 0000", v); end
        bus_read(BASE + 16'd2, 1'b0, v);
        n_cmp++; if (v !== 16'h01B1) begin n_bad++; $display("FAIL midrst_div: got %h want 01b1", v); end
    endtask

    initial begin
        test_reset;
        test_tx_frame;
        test_back_to_back;
        test_ignore;
`ifdef J4_UART_RX_EN
        test_rx_single;
        test_rx_errors;
`else
        test_no_rx;
`endif
        test_mid_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete within 1 ms");
        $fatal(1);
    end
endmodule
